axi4_write_channel_arbiter: RTL and testbench

- Shares one slave-side AXI4 write path among NO_OF_MASTERS master ports.
- Round-robin arbitrates the write address (AW) channel and registers the winner's AW payload onto a single downstream AW channel.
- Records each grant's master index in an in-order routing FIFO. The write data (W) steering logic reads this FIFO and retires one entry per completed burst (wlast handshake).
- Sits between the master agent ports and the slave agent in multi-master configurations.

---
 rtl/axi4_write_channel_arbiter.sv | 82 ++++++++
 tb/tb_axi4_write_channel_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/axi4_write_channel_arbiter.sv
// axi4_write_channel_arbiter: round-robin AW arbiter with in-order W routing FIFO
module axi4_write_channel_arbiter #(
  parameter int NO_OF_MASTERS          = 4,
  parameter int ADDRESS_WIDTH          = 32,
  parameter int ID_WIDTH               = 4,
  parameter int OUTSTANDING_FIFO_DEPTH = 16,
  parameter int IDX_WIDTH              = $clog2(NO_OF_MASTERS)
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [NO_OF_MASTERS-1:0]           m_awvalid,
  output logic [NO_OF_MASTERS-1:0]           m_awready,
  input  logic [NO_OF_MASTERS*ID_WIDTH-1:0]  m_awid,
  input  logic [NO_OF_MASTERS*ADDRESS_WIDTH-1:0] m_awaddr,
  input  logic [NO_OF_MASTERS*8-1:0]         m_awlen,
  output logic                               s_awvalid,
  input  logic                               s_awready,
  output logic [ID_WIDTH-1:0]                s_awid,
  output logic [ADDRESS_WIDTH-1:0]           s_awaddr,
  output logic [7:0]                         s_awlen,
  input  logic                               w_last_fire,
  output logic                               w_route_valid,
  output logic [IDX_WIDTH-1:0]               w_route_idx,
  output logic                               route_full,
  output logic                               route_err
);
  localparam int PW = $clog2(OUTSTANDING_FIFO_DEPTH);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nxt;
  logic [IDX_WIDTH-1:0] last_grant, winner, idx;
  logic [IDX_WIDTH-1:0] route_mem [OUTSTANDING_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic grant, pop;
  // Scan from the farthest candidate down so the nearest valid master after last_grant wins.
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = NO_OF_MASTERS; k >= 1; k--) begin
      idx = IDX_WIDTH'((int'(last_grant) + k) % NO_OF_MASTERS);
      if (m_awvalid[idx]) winner = idx;
    end
  end
  assign grant         = state == IDLE && |m_awvalid && !route_full;
  assign m_awready     = grant ? NO_OF_MASTERS'(1) << winner : '0;
  assign pop           = w_last_fire && count != '0;
  assign route_full    = count == (PW+1)'(OUTSTANDING_FIFO_DEPTH);
  assign w_route_valid = count != '0;
  assign s_awvalid     = state == HOLD;
  always_comb state_nxt = state == IDLE ? (grant ? HOLD : IDLE) : (s_awready ? IDLE : HOLD);
  always_ff @(posedge aclk)
    if (grant) route_mem[wr_ptr] <= winner;
  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= IDLE;
      last_grant  <= IDX_WIDTH'(NO_OF_MASTERS - 1);
      s_awid      <= '0;
      s_awaddr    <= '0;
      s_awlen     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      w_route_idx <= '0;
      route_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        s_awid     <= m_awid[winner*ID_WIDTH +: ID_WIDTH];
        s_awaddr   <= m_awaddr[winner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        s_awlen    <= m_awlen[winner*8 +: 8];
        wr_ptr     <= wr_ptr + 1'b1;
        last_grant <= winner;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(grant) - (PW+1)'(pop);
      // Head register: a push into an empty (or emptying) FIFO becomes the head directly.
      if (grant && (count == '0 || (pop && count == (PW+1)'(1)))) w_route_idx <= winner;
      else if (pop) w_route_idx <= route_mem[rd_ptr + 1'b1];
      if (w_last_fire && count == '0) route_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi4_write_channel_arbiter.sv
// tb_axi4_write_channel_arbiter: directed + random stimulus against a queue-based reference model
module tb_axi4_write_channel_arbiter;
  localparam int N = 4, AW = 32, IW = 4, D = 16, XW = 2;
  logic aclk = 1'b0, areset;
  logic [N-1:0] m_awvalid, m_awready;
  logic [N*IW-1:0] m_awid;
  logic [N*AW-1:0] m_awaddr;
  logic [N*8-1:0] m_awlen;
  logic s_awvalid, s_awready;
  logic [IW-1:0] s_awid;
  logic [AW-1:0] s_awaddr;
  logic [7:0] s_awlen;
  logic w_last_fire, w_route_valid, route_full, route_err;
  logic [XW-1:0] w_route_idx;

  axi4_write_channel_arbiter #(
    .NO_OF_MASTERS(N), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW), .OUTSTANDING_FIFO_DEPTH(D)
  ) dut (
    .aclk(aclk), .areset(areset), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .w_last_fire(w_last_fire),
    .w_route_valid(w_route_valid), .w_route_idx(w_route_idx),
    .route_full(route_full), .route_err(route_err)
  );

  always #5 aclk = ~aclk;

  bit hold, err;
  int last_g;
  int q[$];
  logic [IW-1:0] e_id;
  logic [AW-1:0] e_addr;
  logic [7:0] e_len;
  int passes = 0, total = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int pick();
    if (hold || q.size() >= D) return -1;
    for (int k = 1; k <= N; k++)
      if (m_awvalid[(last_g + k) % N]) return (last_g + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    hold = 0; err = 0; last_g = N - 1; q.delete();
    e_id = '0; e_addr = '0; e_len = '0;
  endtask

  task automatic set_pl(input int i, input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] l);
    m_awid[i*IW +: IW] = id;
    m_awaddr[i*AW +: AW] = a;
    m_awlen[i*8 +: 8] = l;
  endtask

  task automatic cycle();
    int w;
    logic [N-1:0] exp_rdy;
    @(negedge aclk);
    w = pick();
    exp_rdy = (w < 0) ? '0 : (N'(1) << w);
    chk("m_awready", m_awready, exp_rdy);
    chk("s_awvalid", s_awvalid, hold);
    chk("s_awid", s_awid, e_id);
    chk("s_awaddr", s_awaddr, e_addr);
    chk("s_awlen", s_awlen, e_len);
    chk("w_route_valid", w_route_valid, q.size() > 0);
    chk("route_full", route_full, q.size() == D);
    chk("route_err", route_err, err);
    if (q.size() > 0) chk("w_route_idx", w_route_idx, q[0]);
    @(posedge aclk);
    if (areset) model_reset();
    else begin
      if (w_last_fire) begin
        if (q.size() > 0) void'(q.pop_front());
        else err = 1;
      end
      if (hold && s_awready) hold = 0;
      if (w >= 0) begin
        q.push_back(w);
        e_id = m_awid[w*IW +: IW];
        e_addr = m_awaddr[w*AW +: AW];
        e_len = m_awlen[w*8 +: 8];
        last_g = w;
        hold = 1;
      end
    end
    #1;
  endtask

  initial begin
    areset = 1; m_awvalid = '0; s_awready = 0; w_last_fire = 0;
    m_awid = '0; m_awaddr = '0; m_awlen = '0;
    repeat (2) @(posedge aclk);
    #1 areset = 0;
    model_reset();
    chk("rst_idx", w_route_idx, 0);
    cycle();
    // single master 2
    set_pl(2, 4'd5, 32'h1000, 8'd3);
    m_awvalid = 4'b0100;
    #1 chk("sp_ready", m_awready, 4'b0100);
    cycle();
    m_awvalid = '0;
    chk("sp_id", s_awid, 5);
    chk("sp_addr", s_awaddr, 32'h1000);
    chk("sp_len", s_awlen, 3);
    chk("sp_route", w_route_idx, 2);
    cycle();
    s_awready = 1;
    cycle();
    cycle();
    // fairness
    for (int i = 0; i < N; i++) set_pl(i, IW'(i + 8), AW'(32'h100 * (i + 1)), 8'(i));
    m_awvalid = '1;
    repeat (10) cycle();
    // backpressure
    s_awready = 0;
    repeat (6) cycle();
    s_awready = 1;
    repeat (3) cycle();
    // drain then underflow
    m_awvalid = '0; w_last_fire = 1;
    repeat (D + 2) cycle();
    w_last_fire = 0;
    repeat (3) cycle();
    // fill to full, stall, single pop, refill
    m_awvalid = '1;
    repeat (40) cycle();
    w_last_fire = 1;
    cycle();
    w_last_fire = 0;
    repeat (4) cycle();
    w_last_fire = 1;
    repeat (6) cycle();
    w_last_fire = 0;
    // reset during HOLD
    m_awvalid = 4'b0010; s_awready = 0;
    repeat (3) cycle();
    areset = 1;
    cycle();
    areset = 0; m_awvalid = '1; s_awready = 1;
    cycle();
    chk("rst_winner", w_route_idx, 0);
    // random
    for (int n = 0; n < 600; n++) begin
      m_awvalid = N'($urandom);
      for (int i = 0; i < N; i++) set_pl(i, IW'($urandom), $urandom, 8'($urandom));
      s_awready = $urandom_range(0, 3) != 0;
      w_last_fire = $urandom_range(0, 4) == 0;
      areset = $urandom_range(0, 149) == 0;
      cycle();
    end
    areset = 0;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
